// File: rtl/fetch_pkg.sv
// Shared types, constants and the PC legality check for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    localparam int INSTR_W    = 32;
    localparam int PC_STEP    = 4;
    localparam int MAX_ADDR_W = 64;

    // Written as pc > mem_size-4 so that a PC near the top of the address space stays bad
    // instead of wrapping back into range through pc+3.
    function automatic logic is_bad_pc(input logic [MAX_ADDR_W-1:0] pc,
                                       input logic [MAX_ADDR_W-1:0] mem_size);
        return (pc[1:0] != 2'b00) || (pc > (mem_size - MAX_ADDR_W'(PC_STEP)));
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational ROM and registers
// each word into a single IF/ID slot, with branch redirects and a sticky fetch fault.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int MEM_SIZE = 1024,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               fault,
    output logic [ADDR_W-1:0]  fault_pc,
    output logic [31:0]        fetch_count
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
    logic               fault_q, fault_d;
    logic [ADDR_W-1:0]  fault_pc_q, fault_pc_d;
    logic [31:0]        fetch_count_q, fetch_count_d;

    logic adv;
    logic pc_bad;

    assign adv    = !out_valid_q || out_ready;
    assign pc_bad = is_bad_pc(MAX_ADDR_W'(pc_q), MAX_ADDR_W'(MEM_SIZE));

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;
        fetch_count_d = fetch_count_q;

        if (out_valid_q && out_ready && !redirect_valid) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end

        if (redirect_valid) begin
            // A redirect squashes the slot and spends its cycle loading the new PC.
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
            state_d     = RUN;
            fault_d     = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (adv) begin
                        if (pc_bad) begin
                            state_d     = FAULT;
                            fault_d     = 1'b1;
                            fault_pc_d  = pc_q;
                            out_valid_d = 1'b0;
                        end else begin
                            out_instr_d = imem_instr;
                            out_pc_d    = pc_q;
                            out_valid_d = 1'b1;
                            pc_d        = pc_q + STEP;
                        end
                    end
                end
                FAULT: begin
                    out_valid_d = 1'b0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_pc_q      <= '0;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: preloaded ROM image, directed scenarios, then a randomized phase,
// all checked against a transaction-level model of the fetch stream.
module tb_fetch_ctrl;

    localparam int ADDR_W   = 64;
    localparam int MEM_SIZE = 1024;
    localparam int WORDS    = MEM_SIZE / 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [63:0]       imem_addr;
    logic [31:0]       imem_instr;
    logic              redirect_valid = 1'b0;
    logic [63:0]       redirect_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_instr;
    logic [63:0]       out_pc;
    logic              fault;
    logic [63:0]       fault_pc;
    logic [31:0]       fetch_count;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] rom [WORDS];

    always #5 clk = ~clk;

    // Combinational instruction ROM; the region past the image reads as X.
    assign imem_instr = (imem_addr < 64'(MEM_SIZE)) ? rom[imem_addr[9:2]] : 32'hxxxx_xxxx;

    fetch_ctrl #(.ADDR_W(ADDR_W), .MEM_SIZE(MEM_SIZE), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .fault(fault), .fault_pc(fault_pc), .fetch_count(fetch_count)
    );

    // Reference: a fetch pointer, the instruction sitting in the IF/ID slot, a faulted flag.
    longint unsigned m_next;
    bit              m_have;
    longint unsigned m_slot_pc;
    logic [31:0]     m_slot_word;
    bit              m_faulted;
    longint unsigned m_fault_at;
    longint unsigned m_delivered;

    function automatic logic [31:0] image_word(input longint unsigned addr);
        return 32'h9E37_79B1 * (32'(addr / 4) + 32'd1) ^ 32'h0013_5700;
    endfunction

    function automatic bit illegal(input longint unsigned addr);
        return (addr % 4 != 0) || (addr >= longint'(MEM_SIZE) - 3) || (addr > 64'hFFFF_FFFF_FFFF_FFF0);
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_next = 0; m_have = 0; m_slot_pc = 0; m_slot_word = 0;
            m_faulted = 0; m_fault_at = 0; m_delivered = 0;
        end else if (redirect_valid) begin
            m_next = redirect_pc; m_have = 0; m_faulted = 0;
        end else begin
            bit consumed = m_have && out_ready;
            if (consumed) m_delivered++;
            if (!m_faulted && (!m_have || consumed)) begin
                if (illegal(m_next)) begin
                    m_faulted = 1; m_fault_at = m_next; m_have = 0;
                end else begin
                    m_have = 1; m_slot_pc = m_next; m_slot_word = image_word(m_next);
                    m_next += 4;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 64'(out_valid), 64'(m_have));
        chk("out_pc", out_pc, m_slot_pc);
        chk("out_instr", 64'(out_instr), 64'(m_slot_word));
        chk("imem_addr", imem_addr, m_next);
        chk("fault", 64'(fault), 64'(m_faulted));
        chk("fault_pc", fault_pc, m_fault_at);
        chk("fetch_count", 64'(fetch_count), m_delivered & 64'hFFFF_FFFF);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        redirect_valid = 1'b0;
    endtask

    task automatic redirect_to(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) rom[i] = image_word(longint'(i) * 4);

        // Reset state
        do_reset();
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_pc", imem_addr, 64'd0);

        // Sequential run
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("seq_out_pc", out_pc, 64'd20);
        chk("seq_count", 64'(fetch_count), 64'd5);

        // Backpressure at out_pc=8
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("bp_hold_pc", out_pc, 64'd8);
        chk("bp_hold_addr", imem_addr, 64'd12);
        chk("bp_hold_count", 64'(fetch_count), 64'd2);
        out_ready = 1'b1;
        tick();
        chk("bp_release_pc", out_pc, 64'd12);

        // Redirect squashing a slot that is being handshaken
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        chk("sq_pre_pc", out_pc, 64'h10);
        redirect_to(64'h40);
        chk("sq_valid", 64'(out_valid), 64'd0);
        chk("sq_count", 64'(fetch_count), 64'd4);
        tick();
        chk("sq_new_pc", out_pc, 64'h40);

        // End of memory
        redirect_to(64'h3F8);
        for (int i = 0; i < 3; i++) tick();
        chk("eom_fault", 64'(fault), 64'd1);
        chk("eom_fault_pc", fault_pc, 64'h400);
        tick();
        chk("eom_frozen", imem_addr, 64'h400);

        // Misaligned redirect, then recovery
        redirect_to(64'h22);
        tick();
        chk("mis_fault_pc", fault_pc, 64'h22);
        redirect_to(64'h20);
        chk("mis_cleared", 64'(fault), 64'd0);
        tick();
        chk("mis_out_pc", out_pc, 64'h20);

        // Target near the top of the address space must not wrap into range
        redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("top_fault", 64'(fault), 64'd1);

        // Reset mid-stall
        redirect_to(64'h100);
        tick();
        out_ready = 1'b0;
        tick();
        do_reset();
        chk("rst_stall_valid", 64'(out_valid), 64'd0);
        chk("rst_stall_count", 64'(fetch_count), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("rst_resume_pc", out_pc, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            reset     = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 9) == 0) begin
                redirect_valid = 1'b1;
                case ($urandom_range(0, 4))
                    0: redirect_pc = 64'($urandom_range(0, WORDS - 1)) * 4;
                    1: redirect_pc = 64'h3F0 + 64'($urandom_range(0, 3)) * 4;
                    2: redirect_pc = 64'($urandom_range(0, MEM_SIZE - 1)) | 64'd1;
                    3: redirect_pc = {$urandom, $urandom};
                    default: redirect_pc = 64'($urandom_range(0, 15)) * 4;
                endcase
            end
            tick();
            reset = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
